// File: rtl/dreg_arb_pkg.sv
// ---------------------------------------------------------------------------
// dreg_arb_pkg : shared constants and helpers for the shared-register arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dreg_arb_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Index width that never collapses to zero bits for single-entry vectors.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick : combinational round-robin winner search starting at rr_ptr
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import dreg_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any_req
);

  int               pos;
  logic [IDX_W-1:0] pos_idx;

  // Scan from the far end back toward rr_ptr so the closest asserted request
  // is the last one to overwrite the result.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    pos     = 0;
    pos_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos     = (int'(rr_ptr) + k) % NUM_REQ;
      pos_idx = IDX_W'(pos);
      if (req[pos_idx]) begin
        win_oh          = '0;
        win_oh[pos_idx] = 1'b1;
        win_idx         = pos_idx;
      end
    end
  end

  assign any_req = |req;

endmodule

`default_nettype wire

// File: rtl/dreg_share_arbiter.sv
// ---------------------------------------------------------------------------
// dreg_share_arbiter : round-robin shared storage register with burst lock
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dreg_share_arbiter
  import dreg_arb_pkg::*;
#(
  parameter int  NUM_REQ  = 4,
  parameter int  WIDTH    = 8,
  parameter int  MAX_HOLD = 4,
  localparam int IDX_W    = clog2_min1(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       lock,
  input  logic [NUM_REQ*WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         q,
  output logic [IDX_W-1:0]         q_owner,
  output logic                     q_valid
);

  localparam int HOLD_W = clog2_min1(MAX_HOLD);

  logic [0:0]         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [IDX_W-1:0]   q_owner_q, q_owner_d;
  logic               q_valid_q, q_valid_d;

  logic [WIDTH-1:0]   wdata_arr [NUM_REQ];
  logic [IDX_W-1:0]   next_ptr;
  logic [IDX_W-1:0]   pick_ptr;
  logic [NUM_REQ-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               any_req;
  logic               owner_req;
  logic               stay;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign wdata_arr[i] = wdata[i*WIDTH +: WIDTH];
  end

  always_comb begin
    if (int'(owner_q) == NUM_REQ - 1) next_ptr = '0;
    else                              next_ptr = owner_q + IDX_W'(1);
  end

  // On release the search must already start after the releasing owner.
  assign pick_ptr  = (state_q == ST_GRANT) ? next_ptr : rr_ptr_q;
  assign owner_req = req[owner_q];
  assign stay      = owner_req && lock[owner_q] && (int'(hold_cnt_q) < MAX_HOLD - 1);

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req     (req),
    .rr_ptr  (pick_ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .any_req (any_req)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ack_d      = '0;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    q_d        = q_q;
    q_owner_d  = q_owner_q;
    q_valid_d  = q_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          gnt_d      = win_oh;
          owner_d    = win_idx;
          hold_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (owner_req) begin
          q_d       = wdata_arr[owner_q];
          q_owner_d = owner_q;
          q_valid_d = 1'b1;
          ack_d     = gnt_q;
        end
        if (stay) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end else begin
          rr_ptr_d   = next_ptr;
          hold_cnt_d = '0;
          if (any_req) begin
            gnt_d   = win_oh;
            owner_d = win_idx;
            state_d = ST_GRANT;
          end else begin
            gnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      ack_q      <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      q_q        <= '0;
      q_owner_q  <= '0;
      q_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      q_q        <= q_d;
      q_owner_q  <= q_owner_d;
      q_valid_q  <= q_valid_d;
    end
  end

  assign gnt     = gnt_q;
  assign ack     = ack_q;
  assign q       = q_q;
  assign q_owner = q_owner_q;
  assign q_valid = q_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_dreg_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dreg_share_arbiter : vector table, corner sequences and random run
// against a transaction-level model of the shared-register arbiter
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dreg_share_arbiter;

  localparam int N        = 4;
  localparam int W        = 8;
  localparam int MAX_HOLD = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] lock;
  logic [N*W-1:0] wdata;
  logic [N-1:0] gnt;
  logic [N-1:0] ack;
  logic [W-1:0] q;
  logic [1:0]   q_owner;
  logic         q_valid;

  int checks = 0;
  int errors = 0;

  // Model: who holds the register, how many writes it has made this grant,
  // where the next search starts and what the register holds.
  int         m_owner;
  int         m_writes;
  int         m_ptr;
  int         m_ack;
  logic [7:0] m_q;
  int         m_qown;
  bit         m_qval;

  dreg_share_arbiter #(
    .NUM_REQ  (N),
    .WIDTH    (W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .lock    (lock),
    .wdata   (wdata),
    .gnt     (gnt),
    .ack     (ack),
    .q       (q),
    .q_owner (q_owner),
    .q_valid (q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int idx);
    logic [N-1:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_writes = 0;
    m_ptr    = 0;
    m_ack    = -1;
    m_q      = '0;
    m_qown   = 0;
    m_qval   = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N*W-1:0] d);
    int i;
    bit keep;
    m_ack = -1;
    if (m_owner < 0) begin
      m_owner  = pick(r, m_ptr);
      m_writes = 0;
    end else begin
      i    = m_owner;
      keep = 1'b0;
      if (r[i]) begin
        m_q    = d[i*W +: W];
        m_qown = i;
        m_qval = 1'b1;
        m_ack  = i;
        m_writes++;
        keep   = l[i] && (m_writes < MAX_HOLD);
      end
      if (!keep) begin
        m_ptr    = (i + 1) % N;
        m_owner  = pick(r, m_ptr);
        m_writes = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(req, lock, wdata);
    #1;
    chk("gnt", 32'(gnt), 32'(onehot(m_owner)));
    chk("ack", 32'(ack), 32'(onehot(m_ack)));
    chk("q", 32'(q), 32'(m_q));
    chk("q_owner", 32'(q_owner), 32'(m_qown));
    chk("q_valid", 32'(q_valid), 32'(m_qval));
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_q_owner", 32'(q_owner), 32'h0);
    chk("rst_q_valid", 32'(q_valid), 32'h0);
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  task automatic set_in(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N*W-1:0] d);
    req   = r;
    lock  = l;
    wdata = d;
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic [31:0] wdata;
    logic [3:0] e_gnt;
    logic [3:0] e_ack;
    logic [7:0] e_q;
    logic [1:0] e_own;
    logic       e_val;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int cnt;
    tbl[0] = '{1'b1, 4'b1111, 4'b0000, 32'h44332211, 4'b0001, 4'b0000, 8'h00, 2'd0, 1'b0};
    tbl[1] = '{1'b0, 4'b1111, 4'b0000, 32'h44332211, 4'b0010, 4'b0001, 8'h11, 2'd0, 1'b1};
    tbl[2] = '{1'b0, 4'b1111, 4'b0000, 32'h44332211, 4'b0100, 4'b0010, 8'h22, 2'd1, 1'b1};
    tbl[3] = '{1'b0, 4'b1111, 4'b0000, 32'h44332211, 4'b1000, 4'b0100, 8'h33, 2'd2, 1'b1};
    tbl[4] = '{1'b0, 4'b1111, 4'b0000, 32'h44332211, 4'b0001, 4'b1000, 8'h44, 2'd3, 1'b1};
    tbl[5] = '{1'b0, 4'b0000, 4'b0000, 32'h44332211, 4'b0000, 4'b0000, 8'h44, 2'd3, 1'b1};
    tbl[6] = '{1'b1, 4'b0001, 4'b0000, 32'h000000A5, 4'b0001, 4'b0000, 8'h00, 2'd0, 1'b0};
    tbl[7] = '{1'b0, 4'b0001, 4'b0000, 32'h000000A5, 4'b0001, 4'b0001, 8'hA5, 2'd0, 1'b1};
    tbl[8] = '{1'b0, 4'b0000, 4'b0000, 32'h000000A5, 4'b0000, 4'b0000, 8'hA5, 2'd0, 1'b1};

    reset = 1'b0;
    set_in('0, '0, '0);
    model_reset();
    #1;
    do_reset();

    // Round-robin rotation and single-write latency vectors
    for (int v = 0; v < 9; v++) begin
      if (tbl[v].rst) do_reset();
      set_in(tbl[v].req, tbl[v].lock, tbl[v].wdata);
      tick();
      chk($sformatf("vec%0d_gnt", v), 32'(gnt), 32'(tbl[v].e_gnt));
      chk($sformatf("vec%0d_ack", v), 32'(ack), 32'(tbl[v].e_ack));
      chk($sformatf("vec%0d_q", v), 32'(q), 32'(tbl[v].e_q));
      chk($sformatf("vec%0d_own", v), 32'(q_owner), 32'(tbl[v].e_own));
      chk($sformatf("vec%0d_val", v), 32'(q_valid), 32'(tbl[v].e_val));
    end

    // Reset in the middle of a locked burst
    do_reset();
    set_in(4'b0010, 4'b0010, 32'h00005A00);
    repeat (3) tick();
    chk("midburst_gnt", 32'(gnt), 32'h2);
    do_reset();
    set_in('0, '0, '0);
    tick();
    chk("after_rst_idle_gnt", 32'(gnt), 32'h0);

    // Lock burst limited to MAX_HOLD writes, then handed to the next requester
    do_reset();
    set_in(4'b0100, 4'b0100, 32'h00C30000);
    tick();
    set_in(4'b0101, 4'b0100, 32'h00C3003C);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (ack == 4'b0100) cnt++;
      if (k == 3) chk("burst_handoff_gnt", 32'(gnt), 32'h1);
    end
    chk("burst_len", 32'(cnt), 32'd4);

    // A sole locked requester is re-granted after its burst ends
    do_reset();
    set_in(4'b0100, 4'b0100, 32'h00770000);
    tick();
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (ack == 4'b0100) cnt++;
    end
    chk("sole_regrant_gnt", 32'(gnt), 32'h4);
    chk("sole_regrant_acks", 32'(cnt), 32'd8);

    // Withdrawn request while granted: no write, next requester after it wins
    do_reset();
    set_in(4'b0011, 4'b0000, 32'h00001E0F);
    tick();
    tick();
    chk("wd_pre_gnt", 32'(gnt), 32'h2);
    set_in(4'b0101, 4'b0000, 32'h00001E0F);
    tick();
    chk("wd_ack", 32'(ack), 32'h0);
    chk("wd_q", 32'(q), 32'h0F);
    chk("wd_next_gnt", 32'(gnt), 32'h4);

    // Pointer wrap from requester 3 back to 0
    do_reset();
    set_in(4'b0100, 4'b0000, 32'h99880000);
    tick();
    set_in(4'b1100, 4'b0000, 32'h99880000);
    tick();
    chk("wrap_gnt3", 32'(gnt), 32'h8);
    set_in(4'b1001, 4'b0000, 32'h990000AA);
    tick();
    chk("wrap_q", 32'(q), 32'h99);
    chk("wrap_gnt0", 32'(gnt), 32'h1);

    // Random traffic against the model, with occasional async resets
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      set_in(4'($urandom), 4'($urandom | $urandom), $urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
